sha1_job_sched: RTL

Job scheduler in front of the SHA1 hash core (SHA1_hash_interface).
- Accepts hash jobs (message address, message size, digest destination) from a host into a small FIFO.
- Launches each job on the core with the start pulse and waits for done.
- Writes the 160-bit digest back to DPSRAM as five words.
- Owns DPSRAM port A and muxes it between the core (while hashing) and its own digest writeback.

---
 rtl/sha1_sched_pkg.sv | 21 ++
 rtl/sha1_job_sched_if.sv | 10 +
 rtl/sha1_job_fifo.sv | 44 ++++
 rtl/sha1_job_sched.sv | 110 +++++++++++
 4 files changed

// File: rtl/sha1_sched_pkg.sv
// sha1_sched_pkg: shared types and constants for the SHA1 job scheduler
package sha1_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, RUN, WRITE} state_t;
  typedef struct packed {
    logic [31:0] msg_addr;
    logic [31:0] msg_size;
    logic [31:0] dst_addr;
  } job_t;
  localparam int DIGEST_WORDS = 5;
  localparam int START_CYCLES = 2;
  localparam logic [31:0] SHA1_H0 = 32'h67452301;
  localparam logic [31:0] SHA1_H1 = 32'hefcdab89;
  localparam logic [31:0] SHA1_H2 = 32'h98badcfe;
  localparam logic [31:0] SHA1_H3 = 32'h10325476;
  localparam logic [31:0] SHA1_H4 = 32'hc3d2e1f0;
  function automatic logic [31:0] digest_word(input logic [159:0] h, input logic [2:0] n);
    logic [159:0] s;
    s = h << (32 * n);
    return s[159:128];
  endfunction
endpackage

// File: rtl/sha1_job_sched_if.sv
// sha1_job_sched_if: host-to-scheduler job handshake
interface sha1_job_sched_if;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_msg_addr;
  logic [31:0] job_msg_size;
  logic [31:0] job_dst_addr;
  modport master (output job_valid, job_msg_addr, job_msg_size, job_dst_addr, input job_ready);
  modport slave  (input job_valid, job_msg_addr, job_msg_size, job_dst_addr, output job_ready);
endinterface

// File: rtl/sha1_job_fifo.sv
// sha1_job_fifo: synchronous FIFO of job descriptors with registered count
module sha1_job_fifo import sha1_sched_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push,
  input  logic                     pop,
  input  job_t                     din,
  output job_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  job_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_comb begin
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/sha1_job_sched.sv
// sha1_job_sched: queues hash jobs, runs them on the SHA1 core, writes digests back
module sha1_job_sched import sha1_sched_pkg::*; #(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  sha1_job_sched_if.slave      host,
  output logic                 core_start,
  output logic [31:0]          core_msg_addr,
  output logic [31:0]          core_msg_size,
  input  logic                 core_done,
  input  logic [159:0]         core_hash,
  input  logic [15:0]          core_mem_addr,
  input  logic                 core_mem_we,
  input  logic [31:0]          core_mem_wdata,
  output logic [15:0]          mem_addr,
  output logic                 mem_we,
  output logic [31:0]          mem_wdata,
  output logic                 busy,
  output logic [CNT_W-1:0]     jobs_done,
  output logic                 err_align
);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  job_t job_q, job_d, head, in_job;
  logic [159:0] digest_q, digest_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic err_q, err_d, pop, full, empty;
  logic [$clog2(QDEPTH):0] fifo_cnt;
  assign in_job = '{msg_addr: host.job_msg_addr, msg_size: host.job_msg_size, dst_addr: host.job_dst_addr};
  sha1_job_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk(clk), .nreset(nreset), .push(host.job_valid), .pop(pop), .din(in_job),
    .dout(head), .full(full), .empty(empty), .count(fifo_cnt)
  );
  assign host.job_ready = !full;
  assign core_msg_addr  = job_q.msg_addr;
  assign core_msg_size  = job_q.msg_size;
  assign busy           = state_q != IDLE || fifo_cnt != '0;
  assign jobs_done      = done_q;
  assign err_align      = err_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    job_d      = job_q;
    digest_d   = digest_q;
    done_d     = done_q;
    err_d      = err_q;
    pop        = 1'b0;
    core_start = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        // misaligned jobs are dropped here so the core never sees them
        if (head.msg_addr[1:0] != 2'b0 || head.dst_addr[1:0] != 2'b0) err_d = 1'b1;
        else begin
          job_d   = head;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        core_start = 1'b1;
        cnt_d      = cnt_q + 3'd1;
        state_d    = cnt_q == 3'(START_CYCLES - 1) ? RUN : START;
      end
      RUN: begin
        mem_addr  = core_mem_addr;
        mem_we    = core_mem_we;
        mem_wdata = core_mem_wdata;
        if (core_done) begin
          digest_d = core_hash;
          cnt_d    = '0;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = job_q.dst_addr[15:0] + {11'b0, cnt_q, 2'b0};
        mem_wdata = digest_word(digest_q, cnt_q);
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'(DIGEST_WORDS - 1)) begin
          done_d  = done_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      job_q    <= '0;
      digest_q <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      job_q    <= job_d;
      digest_q <= digest_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule
